seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_glyph_decode.sv | 42 ++++
 rtl/seg7_scan_driver.sv | 123 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the 8-digit seven-segment scan driver:
//               glyph codes, active-low segment patterns (seg[0]=a..seg[6]=g),
//               digit count and a small leading-pad helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int DIGITS  = 8;
    localparam int GLYPH_W = 5;

    typedef logic [GLYPH_W-1:0] glyph_t;
    typedef logic [6:0]         seg_t;

    // Glyph codes outside the 0x00-0x0F hex range
    localparam glyph_t GLYPH_ZERO  = 5'h00;
    localparam glyph_t GLYPH_BLANK = 5'h10;
    localparam glyph_t GLYPH_DASH  = 5'h11;

    // Active-low segment patterns, bit order g f e d c b a
    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_B     = 7'h03;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_D     = 7'h21;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_F     = 7'h0E;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_BLANK = 7'h7F;

    // A digit counts as leading padding if it is a literal zero or a blank
    function automatic logic is_lead_pad(input glyph_t g);
        return (g == GLYPH_ZERO) || (g == GLYPH_BLANK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_decode
// Description : Combinational 5-bit glyph code to active-low 7-segment
//               pattern. 0x00-0x0F hex digits, 0x11 dash, everything else
//               blank.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    // Pure lookup; unlisted codes fall through to blank
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            5'h00:      o_seg = SEG_0;
            5'h01:      o_seg = SEG_1;
            5'h02:      o_seg = SEG_2;
            5'h03:      o_seg = SEG_3;
            5'h04:      o_seg = SEG_4;
            5'h05:      o_seg = SEG_5;
            5'h06:      o_seg = SEG_6;
            5'h07:      o_seg = SEG_7;
            5'h08:      o_seg = SEG_8;
            5'h09:      o_seg = SEG_9;
            5'h0A:      o_seg = SEG_A;
            5'h0B:      o_seg = SEG_B;
            5'h0C:      o_seg = SEG_C;
            5'h0D:      o_seg = SEG_D;
            5'h0E:      o_seg = SEG_E;
            5'h0F:      o_seg = SEG_F;
            GLYPH_DASH: o_seg = SEG_DASH;
            default:    o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed 8-digit seven-segment driver. Each digit gets
//               REFRESH_DIV clocks, the first GUARD of which keep all anodes
//               off. display/dp_mask are snapshotted once per frame so a frame
//               never mixes two values. All outputs are registered.
//               Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank
//               leading zeros in digits 7..1.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 25000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] display,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int                SLOT_W      = $clog2(REFRESH_DIV);
    localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] C_GUARD     = SLOT_W'(GUARD);

    logic [SLOT_W-1:0] r_slot;
    logic [2:0]        r_idx;
    logic [39:0]       r_shadow_disp;
    logic [7:0]        r_shadow_dp;

    glyph_t            w_glyph [DIGITS];
    logic [DIGITS-1:0] w_lz_blank;
    glyph_t            w_code;
    seg_t              w_seg;
    logic              w_guard;
    logic              w_frame_start;

    assign w_guard       = (r_slot < C_GUARD);
    assign w_frame_start = (r_idx == 3'd0) && (r_slot == '0);

    // View the packed shadow as one glyph per digit
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
            assign w_glyph[gi] = r_shadow_disp[gi*GLYPH_W +: GLYPH_W];
        end
    endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk from the leftmost digit down; a zero is blanked only while every
    // digit above it is still padding. Digit 0 always shows.
    always_comb begin : p_lz
        logic w_pad_above;
        w_pad_above = 1'b1;
        w_lz_blank  = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_lz_blank[d] = w_pad_above && (w_glyph[d] == GLYPH_ZERO);
            w_pad_above   = w_pad_above && is_lead_pad(w_glyph[d]);
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    assign w_code = w_lz_blank[r_idx] ? GLYPH_BLANK : w_glyph[r_idx];

    seg7_glyph_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    // Slot counter wraps every REFRESH_DIV clocks and steps the digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot <= '0;
            r_idx  <= 3'd0;
        end else if (r_slot == C_SLOT_LAST) begin
            r_slot <= '0;
            r_idx  <= r_idx + 3'd1;
        end else begin
            r_slot <= r_slot + SLOT_W'(1);
        end
    end

    // Snapshot inputs at the start of each frame and flag it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow_disp <= {DIGITS{GLYPH_BLANK}};
            r_shadow_dp   <= '0;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= w_frame_start;
            if (w_frame_start) begin
                r_shadow_disp <= display;
                r_shadow_dp   <= dp_mask;
            end
        end
    end

    // Registered drive: dark during the guard window, else the selected digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (w_guard) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'h01 << r_idx);
            seg <= w_seg;
            dp  <= ~r_shadow_dp[r_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               REFRESH_DIV = 8, GUARD = 2 (64 clocks per frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = DIV * 8;

    localparam logic [39:0] DISP_A    = {5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08};
    localparam logic [39:0] DISP_DASH = {8{5'h11}};
    localparam logic [39:0] DISP_LZ   = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h04, 5'h02};
    localparam logic [39:0] DISP_MIX  = {5'h15, 5'h10, 5'h00, 5'h0A, 5'h0F, 5'h11, 5'h00, 5'h0C};

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] display;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int          n_checks = 0;
    int          n_errors = 0;
    int          k = 0;
    logic [39:0] sh_disp;
    logic [7:0]  sh_dp;

    seg7_scan_driver #(
        .REFRESH_DIV (DIV),
        .GUARD       (GRD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .display    (display),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-written segment table, gfedcba active-low
    function automatic logic [6:0] ref_seg(input logic [4:0] g);
        case (g)
            5'h00: return 7'h40;
            5'h01: return 7'h79;
            5'h02: return 7'h24;
            5'h03: return 7'h30;
            5'h04: return 7'h19;
            5'h05: return 7'h12;
            5'h06: return 7'h02;
            5'h07: return 7'h78;
            5'h08: return 7'h00;
            5'h09: return 7'h10;
            5'h0A: return 7'h08;
            5'h0B: return 7'h03;
            5'h0C: return 7'h46;
            5'h0D: return 7'h21;
            5'h0E: return 7'h06;
            5'h0F: return 7'h0E;
            5'h11: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic bit ref_lz(input logic [39:0] d, input int dig);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        logic [4:0] g;
        if (dig == 0) return 1'b0;
        g = d[dig*5 +: 5];
        if (g != 5'h00) return 1'b0;
        for (int j = dig + 1; j < 8; j++) begin
            g = d[j*5 +: 5];
            if (g != 5'h00 && g != 5'h10) return 1'b0;
        end
        return 1'b1;
`else
        return (d[0] & ~d[0]) && (dig < 0);
`endif
    endfunction

    task automatic check_outputs();
        int         slot;
        int         dig;
        bit         guard;
        logic [4:0] g;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        slot  = k % DIV;
        dig   = (k / DIV) % 8;
        guard = (slot < GRD);
        g     = sh_disp[dig*5 +: 5];
        if (ref_lz(sh_disp, dig)) g = 5'h10;
        e_an  = guard ? 8'hFF : ~(8'h01 << dig);
        e_seg = guard ? 7'h7F : ref_seg(g);
        e_dp  = guard ? 1'b1  : ~sh_dp[dig];
        check($sformatf("an@%0d", k),  32'(an),  32'(e_an));
        check($sformatf("seg@%0d", k), 32'(seg), 32'(e_seg));
        check($sformatf("dp@%0d", k),  32'(dp),  32'(e_dp));
        check($sformatf("ft@%0d", k),  32'(frame_tick), 32'(k % FRAME == 0));
    endtask

    // Each cycle: model the frame snapshot at the edge, compare at the negedge
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (k % FRAME == 0) begin
                sh_disp = display;
                sh_dp   = dp_mask;
            end
            @(negedge clk);
            check_outputs();
            k++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_an"},  32'(an),  32'h0FF);
        check({tag, "_seg"}, 32'(seg), 32'h07F);
        check({tag, "_dp"},  32'(dp),  32'h1);
        check({tag, "_ft"},  32'(frame_tick), 32'h0);
    endtask

    initial begin
        reset   = 1'b1;
        display = 40'h0;
        dp_mask = 8'h00;
        sh_disp = {8{5'h10}};
        sh_dp   = 8'h00;
        #3 reset = 1'b0;
        #1 check_reset_state("rst0");
        repeat (2) @(negedge clk);
        check_reset_state("rst1");
        reset = 1'b1;

        // Frame 0: all zeros; new value set late in the frame must not show yet
        run_cycles(FRAME - 4);
        display = DISP_A;
        dp_mask = 8'h04;
        run_cycles(4);
        // Frame 1: digits 8..1 with dp on digit 2
        run_cycles(FRAME);
        // Frame 2: change while digit 3 is lit, rest of frame keeps old value
        run_cycles(3 * DIV + 5);
        display = DISP_DASH;
        dp_mask = 8'hFF;
        run_cycles(FRAME - (3 * DIV + 5));
        // Frame 3: dashes with every dp lit
        run_cycles(FRAME);
        display = DISP_LZ;
        dp_mask = 8'h00;
        run_cycles(FRAME);
        display = DISP_MIX;
        dp_mask = 8'h81;
        run_cycles(FRAME);
        // Frame 6: reset mid-slot in digit 5
        run_cycles(5 * DIV + 5);
        #2 reset = 1'b0;
        #1 check_reset_state("rst_mid");
        @(negedge clk);
        check_reset_state("rst_hold");
        reset = 1'b1;
        k = 0;
        run_cycles(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
